// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with registered read, out-of-range handling and a
// clear engine that fills every word with CLR_VAL after reset or on request.
module ram_sdp_clr #(
    parameter int                 DATA_W  = 16,
    parameter int                 ADDR_W  = 4,
    parameter int                 DEPTH   = 16,
    parameter int                 RD_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] d_out,
    output logic              r_valid,
    output logic              busy,
    output logic              acc_drop
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              r_valid_q, r_valid_d;
    logic              busy_q, busy_d;
    logic              acc_drop_q, acc_drop_d;

    logic              wr_ok, rd_ok, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata, rd_word;

    assign wr_ok   = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok   = {1'b0, rd_addr} < DEPTH_L;
    assign rd_word = mem[rd_addr];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        d_out_d    = d_out_q;
        r_valid_d  = 1'b0;
        busy_d     = busy_q;
        acc_drop_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = data_in;
        case (state_q)
            CLEAR: begin
                // The clear engine owns the write port; user traffic is refused.
                mem_we     = 1'b1;
                mem_waddr  = clr_ptr_q;
                mem_wdata  = CLR_VAL;
                acc_drop_d = w_en | r_en;
                if (clr_ptr_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                mem_we     = w_en & wr_ok;
                acc_drop_d = (w_en & ~wr_ok) | (r_en & ~rd_ok);
                if (r_en) begin
                    r_valid_d = 1'b1;
                    if (!rd_ok)
                        d_out_d = CLR_VAL;
                    else if (RD_MODE == 1 && w_en && wr_addr == rd_addr)
                        d_out_d = data_in;
                    else
                        d_out_d = rd_word;
                end
                // Accesses in this cycle still complete; the pass starts next cycle.
                if (clr) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            d_out_q    <= '0;
            r_valid_q  <= 1'b0;
            busy_q     <= 1'b1;
            acc_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            d_out_q    <= d_out_d;
            r_valid_q  <= r_valid_d;
            busy_q     <= busy_d;
            acc_drop_q <= acc_drop_d;
        end
    end

    // No reset on the array: contents survive rst and are rewritten by the pass.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[mem_waddr] <= mem_wdata;
    end

    assign d_out    = d_out_q;
    assign r_valid  = r_valid_q;
    assign busy     = busy_q;
    assign acc_drop = acc_drop_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Three RAM variants (16/read-first, 16/write-first, 12/read-first) share one
// stimulus stream and are each checked against an abstract array model.
module tb_ram_sdp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, w_en, r_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] data_in;

    logic [15:0] d0, d1, d2;
    logic        rv0, rv1, rv2, b0, b1, b2, ad0, ad1, ad2;
    logic [15:0] dq [3];
    logic        rvq [3], bq [3], dropq [3];

    assign dq[0] = d0;   assign dq[1] = d1;   assign dq[2] = d2;
    assign rvq[0] = rv0; assign rvq[1] = rv1; assign rvq[2] = rv2;
    assign bq[0] = b0;   assign bq[1] = b1;   assign bq[2] = b2;
    assign dropq[0] = ad0; assign dropq[1] = ad1; assign dropq[2] = ad2;

    ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .CLR_VAL(16'hA5A5)) u_rf (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wr_addr(wr_addr), .data_in(data_in),
        .r_en(r_en), .rd_addr(rd_addr), .d_out(d0), .r_valid(rv0), .busy(b0), .acc_drop(ad0));
    ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .CLR_VAL(16'h0000)) u_wf (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wr_addr(wr_addr), .data_in(data_in),
        .r_en(r_en), .rd_addr(rd_addr), .d_out(d1), .r_valid(rv1), .busy(b1), .acc_drop(ad1));
    ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_MODE(0), .CLR_VAL(16'h5A5A)) u_d12 (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wr_addr(wr_addr), .data_in(data_in),
        .r_en(r_en), .rd_addr(rd_addr), .d_out(d2), .r_valid(rv2), .busy(b2), .acc_drop(ad2));

    // Reference model: a whole-array fill at the start of a pass is observably
    // identical to a word-per-cycle sweep, because all access is refused while busy.
    int          dep  [3] = '{16, 16, 12};
    int          mode [3] = '{0, 1, 0};
    logic [15:0] cv   [3] = '{16'hA5A5, 16'h0000, 16'h5A5A};
    logic [15:0] mm   [3][16];
    int          bcnt [3];
    logic [15:0] ed   [3];
    logic        erv  [3];
    logic        edrop[3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_fill(input int k);
        for (int a = 0; a < 16; a++) mm[k][a] = (a < dep[k]) ? cv[k] : 16'hxxxx;
        bcnt[k] = dep[k];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            model_fill(k);
            ed[k] = 16'h0000; erv[k] = 1'b0; edrop[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (bcnt[k] > 0) begin
                bcnt[k]--;
                erv[k]   = 1'b0;
                edrop[k] = w_en | r_en;
            end else begin
                bit wo, ro;
                wo = w_en && (int'(wr_addr) >= dep[k]);
                ro = r_en && (int'(rd_addr) >= dep[k]);
                edrop[k] = wo | ro;
                erv[k]   = r_en;
                if (r_en) begin
                    if (ro) ed[k] = cv[k];
                    else if (w_en && wr_addr == rd_addr && mode[k] == 1) ed[k] = data_in;
                    else ed[k] = mm[k][rd_addr];
                end
                if (w_en && !wo) mm[k][wr_addr] = data_in;
                if (clr) model_fill(k);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; w_en = 0; r_en = 0; wr_addr = 0; rd_addr = 0; data_in = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dq[k] !== 16'h0000) begin n_bad++; $display("FAIL reset_dout inst%0d got %h exp 0000", k, dq[k]); end
            n_cmp++; if (rvq[k] !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid inst%0d got %b exp 0", k, rvq[k]); end
            n_cmp++; if (bq[k] !== 1'b1) begin n_bad++; $display("FAIL reset_busy inst%0d got %b exp 1", k, bq[k]); end
            n_cmp++; if (dropq[k] !== 1'b0) begin n_bad++; $display("FAIL reset_drop inst%0d got %b exp 0", k, dropq[k]); end
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (bq[0] !== (i < 16)) begin n_bad++; $display("FAIL release_busy edge%0d got %b exp %b", i, bq[0], (i < 16)); end
            for (int k = 1; k < 3; k++) begin
                n_cmp++; if (bq[k] !== (bcnt[k] > 0)) begin n_bad++; $display("FAIL release_busy inst%0d edge%0d got %b exp %b", k, i, bq[k], (bcnt[k] > 0)); end
            end
        end
        for (int a = 0; a < 16; a++) begin
            r_en = 1; rd_addr = 4'(a);
            tick();
            n_cmp++; if (dq[0] !== 16'hA5A5 || rvq[0] !== 1'b1 || dropq[0] !== 1'b0) begin
                n_bad++; $display("FAIL clear_read addr%0d got %h/%b/%b exp a5a5/1/0", a, dq[0], rvq[0], dropq[0]); end
            for (int k = 1; k < 3; k++) begin
                n_cmp++; if (dq[k] !== ed[k] || rvq[k] !== erv[k] || dropq[k] !== edrop[k]) begin
                    n_bad++; $display("FAIL clear_read inst%0d addr%0d got %h/%b/%b exp %h/%b/%b", k, a, dq[k], rvq[k], dropq[k], ed[k], erv[k], edrop[k]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        w_en = 1; wr_addr = 3; data_in = 16'h1234;
        tick();
        w_en = 0; r_en = 1; rd_addr = 3;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dq[k] !== 16'h1234 || rvq[k] !== 1'b1) begin
                n_bad++; $display("FAIL write_read inst%0d got %h/%b exp 1234/1", k, dq[k], rvq[k]); end
        end
        r_en = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rvq[k] !== 1'b0 || dq[k] !== 16'h1234) begin
                n_bad++; $display("FAIL rvalid_pulse inst%0d got %h/%b exp 1234/0", k, dq[k], rvq[k]); end
        end
    endtask

    task automatic test_collision();
        w_en = 1; wr_addr = 5; data_in = 16'h0001;
        tick();
        r_en = 1; rd_addr = 5; data_in = 16'hBEEF;
        tick();
        n_cmp++; if (dq[0] !== 16'h0001) begin n_bad++; $display("FAIL collide_read_first got %h exp 0001", dq[0]); end
        n_cmp++; if (dq[1] !== 16'hBEEF) begin n_bad++; $display("FAIL collide_write_first got %h exp beef", dq[1]); end
        w_en = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dq[k] !== 16'hBEEF || rvq[k] !== 1'b1) begin
                n_bad++; $display("FAIL collide_after inst%0d got %h/%b exp beef/1", k, dq[k], rvq[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        w_en = 1; wr_addr = 13; data_in = 16'h7777;
        tick();
        n_cmp++; if (dropq[2] !== 1'b1) begin n_bad++; $display("FAIL oob_write_drop got %b exp 1", dropq[2]); end
        n_cmp++; if (dropq[0] !== 1'b0) begin n_bad++; $display("FAIL inrange_write_drop got %b exp 0", dropq[0]); end
        w_en = 0; r_en = 1; rd_addr = 14;
        tick();
        n_cmp++; if (dq[2] !== 16'h5A5A || rvq[2] !== 1'b1 || dropq[2] !== 1'b1) begin
            n_bad++; $display("FAIL oob_read got %h/%b/%b exp 5a5a/1/1", dq[2], rvq[2], dropq[2]); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (dq[k] !== ed[k] || rvq[k] !== erv[k] || dropq[k] !== edrop[k]) begin
                    n_bad++; $display("FAIL oob_scan inst%0d addr%0d got %h/%b/%b exp %h/%b/%b", k, a, dq[k], rvq[k], dropq[k], ed[k], erv[k], edrop[k]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear_request();
        logic [15:0] held;
        clr = 1; w_en = 1; wr_addr = 2; data_in = 16'h00FF;
        tick();
        idle_inputs();
        held = dq[0];
        r_en = 1; rd_addr = 2;
        for (int i = 1; i <= 16; i++) begin
            clr = (i == 5);
            tick();
            r_en = 0;
            if (i == 1) begin
                n_cmp++; if (dropq[0] !== 1'b1 || rvq[0] !== 1'b0 || dq[0] !== held) begin
                    n_bad++; $display("FAIL busy_read got %h/%b/%b exp %h/0/1", dq[0], rvq[0], dropq[0], held); end
            end
            n_cmp++; if (bq[0] !== (i < 16)) begin n_bad++; $display("FAIL clr_busy edge%0d got %b exp %b", i, bq[0], (i < 16)); end
            for (int k = 1; k < 3; k++) begin
                n_cmp++; if (bq[k] !== (bcnt[k] > 0) || dropq[k] !== edrop[k]) begin
                    n_bad++; $display("FAIL clr_busy inst%0d edge%0d got %b/%b exp %b/%b", k, i, bq[k], dropq[k], (bcnt[k] > 0), edrop[k]); end
            end
        end
        clr = 0; r_en = 1; rd_addr = 2;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dq[k] !== cv[k] || rvq[k] !== 1'b1) begin
                n_bad++; $display("FAIL clr_overwrite inst%0d got %h/%b exp %h/1", k, dq[k], rvq[k], cv[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_pass();
        for (int a = 0; a < 16; a++) begin
            w_en = 1; wr_addr = 4'(a); data_in = 16'(a * 3 + 1);
            tick();
        end
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1; model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dq[k] !== 16'h0000 || rvq[k] !== 1'b0 || bq[k] !== 1'b1 || dropq[k] !== 1'b0) begin
                n_bad++; $display("FAIL midpass_reset inst%0d got %h/%b/%b/%b exp 0000/0/1/0", k, dq[k], rvq[k], bq[k], dropq[k]); end
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (bq[0] !== (i < 16)) begin n_bad++; $display("FAIL midpass_busy edge%0d got %b exp %b", i, bq[0], (i < 16)); end
        end
        for (int a = 0; a < 16; a++) begin
            r_en = 1; rd_addr = 4'(a);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (dq[k] !== cv[k] || rvq[k] !== 1'b1) begin
                    n_bad++; $display("FAIL midpass_read inst%0d addr%0d got %h/%b exp %h/1", k, a, dq[k], rvq[k], cv[k]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            w_en    = ($urandom_range(0, 2) != 0);
            r_en    = ($urandom_range(0, 2) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            data_in = 16'($urandom);
            clr     = ($urandom_range(0, 59) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (dq[k] !== ed[k] || rvq[k] !== erv[k] || dropq[k] !== edrop[k] || bq[k] !== (bcnt[k] > 0)) begin
                    n_bad++; $display("FAIL random cyc%0d inst%0d got %h/%b/%b/%b exp %h/%b/%b/%b", i, k,
                        dq[k], rvq[k], dropq[k], bq[k], ed[k], erv[k], edrop[k], (bcnt[k] > 0)); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_clear_request();
        test_reset_mid_pass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised simple-dual-port synchronous RAM: one write port and one read port, with a registered read output and a `r_valid` qualifier. A built-in clear engine initialises every location to a constant after reset and on request, so contents are defined without a reset on the array. It is the general-purpose storage macro for the datapath and replaces fixed 16x16 instances.

## Interface
- `DATA_W`, 16: word width in bits, ≥1.
- `ADDR_W`, 4: address width in bits, ≥1.
- `DEPTH`, 16: number of words; 2 ≤ DEPTH ≤ 2**ADDR_W.
- `RD_MODE`, 0: collision policy. 0 = read-first (old data), 1 = write-first (new data).
- `CLR_VAL`, 0: DATA_W-bit value written by the clear engine.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: start a clear pass; sampled only when idle.
- `w_en` in 1: write request.
- `wr_addr` in ADDR_W: write address.
- `data_in` in DATA_W: write data.
- `r_en` in 1: read request.
- `rd_addr` in ADDR_W: read address.
- `d_out` out DATA_W: registered read data; holds its last value when no read completes.
- `r_valid` out 1: one-cycle pulse, `d_out` updated this cycle.
- `busy` out 1: clear engine active; user accesses are refused.
- `acc_drop` out 1: one-cycle pulse, an access was refused (busy or out of range).

## Operation
- FSM states: CLEAR and IDLE. There is no other state.
- `rst` asserted: the FSM goes to CLEAR and `clr_ptr` is set to 0. Outputs are driven asynchronously to `d_out`=0, `r_valid`=0, `busy`=1, `acc_drop`=0. Array contents are untouched by reset.
- CLEAR, each clock edge:
  - `mem[clr_ptr]` ← CLR_VAL, then `clr_ptr` increments.
  - When `clr_ptr`==DEPTH-1, that location is written and the FSM goes to IDLE with `busy`=0.
  - A pass is therefore exactly DEPTH cycles.
- IDLE with `clr`=1: the FSM goes to CLEAR and `clr_ptr` is set to 0. In that same cycle any `w_en`/`r_en` is still serviced normally; `clr` takes effect from the next cycle.
- `clr` while in CLEAR: ignored. No restart and no extension of the pass.
- Write in IDLE: `w_en`=1 and `wr_addr`<DEPTH gives `mem[wr_addr]` ← `data_in`.
- Read in IDLE: `r_en`=1 and `rd_addr`<DEPTH gives `d_out` ← `mem[rd_addr]` and `r_valid`=1 on the next edge.
- Read and write are independent and may be asserted in the same cycle.
- Collision (both enabled, same in-range address):
  - RD_MODE=0: `d_out` gets the pre-write contents.
  - RD_MODE=1: `d_out` gets `data_in`.
  - The write always lands.
- Out-of-range address (≥DEPTH):
  - Write: dropped, memory unchanged.
  - Read: `d_out` ← CLR_VAL with `r_valid`=1.
  - Either case: `acc_drop`=1.
- Access while `busy`: the write is dropped, the read produces no `r_valid`, `d_out` is held, and `acc_drop`=1.
- `acc_drop` is a single pulse even if both ports are refused in the same cycle.
- No read completes: `d_out` holds its value. It is never driven to Z or X.

## Timing
- Read latency is 1 cycle: request at edge N, then `d_out`/`r_valid` are valid after edge N, for one cycle.
- Back-to-back reads every cycle are supported, giving one `r_valid` per cycle.
- Write-to-read on different cycles: a read at edge N+1 of an address written at edge N returns the new data.
- After `rst` is released: `busy`=1 for DEPTH rising edges. The first accepted access is at edge DEPTH+1, counting the first edge after release as edge 1.
- `clr` accepted at edge N: `busy`=1 after edge N through edge N+DEPTH, then 0.
- `rst` mid-pass: the pass restarts from address 0 after release. Partial clears and earlier data are not relied on.
- `acc_drop` and `r_valid` are registered and fall after one cycle unless retriggered.

## Test plan
- Reset release, DEPTH=16, CLR_VAL=16'hA5A5: `busy`=1 for exactly 16 edges. Then read all 16 addresses: each returns 16'hA5A5 with `r_valid`, and `acc_drop` stays 0.
- Write 16'h1234 to address 3, then read address 3 on the next cycle: `d_out`=16'h1234 with `r_valid`=1 one cycle after `r_en`.
- Location 5 holds 16'h0001. Write 16'hBEEF to address 5 while reading 5 in the same cycle:
  - RD_MODE=0: read returns 16'h0001, and a following read returns 16'hBEEF.
  - RD_MODE=1: read returns 16'hBEEF.
- DEPTH=12, ADDR_W=4: write address 13 gives `acc_drop`=1 and no change to memory. Read address 14 gives `d_out`=CLR_VAL, `r_valid`=1, `acc_drop`=1.
- `clr` in IDLE with `w_en` to address 2 (16'h00FF) in the same cycle: the write lands, then is overwritten. `busy`=1 for 16 cycles. A read during `busy` gives `acc_drop`=1, no `r_valid`, and `d_out` held. After `busy` falls, a read of address 2 returns CLR_VAL.
- Assert `rst` when `clr_ptr`=7 during a pass: outputs return to reset values immediately. After release the pass takes a full 16 cycles and all locations read CLR_VAL.
